// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max-pool stage for a raster-order pixel stream.
// Uses a half-width line buffer of horizontal pair maxima; never stalls the producer.
module max_pool_2x2 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] pool_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int COL_W    = $clog2(IMG_WIDTH);
    localparam int ROW_W    = $clog2(IMG_HEIGHT);
    localparam int LB_DEPTH = IMG_WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] linebuf [LB_DEPTH];

    logic [LB_AW-1:0]      lb_idx;
    logic [DATA_WIDTH-1:0] lb_rd;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] win_max;
    logic                  col_last;
    logic                  row_last;

    always_comb begin
        lb_idx   = LB_AW'(col >> 1);
        lb_rd    = linebuf[lb_idx];
        pair_max = (hold > pixel_in) ? hold : pixel_in;
        win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
        col_last = (col == COL_LAST);
        row_last = (row == ROW_LAST);
    end

    // Line buffer has no reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (!rst && valid_in && col[0] && !row[0]) begin
            linebuf[lb_idx] <= pair_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            pool_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                if (!col[0]) begin
                    hold <= pixel_in;
                end else if (row[0]) begin
                    pool_out  <= win_max;
                    valid_out <= 1'b1;
                end

                frame_done <= col_last && row_last;

                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2: a 4x4 instance and a 5x3 instance, scoreboard of window maxima.
module tb_max_pool_2x2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pixel_in;
    logic       v0, v1;
    logic [7:0] po0, po1;
    logic       vo0, vo1, fd0, fd1;

    always #5 clk = ~clk;

    max_pool_2x2 #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut0 (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(v0),
        .pool_out(po0), .valid_out(vo0), .frame_done(fd0)
    );

    max_pool_2x2 #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(3)) dut1 (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(v1),
        .pool_out(po1), .valid_out(vo1), .frame_done(fd1)
    );

    int errors = 0;
    int checks = 0;

    int sel;
    int mw, mh, mcol, mrow;
    logic [7:0] frame [0:3][0:4];
    logic [7:0] exp_q [$];
    logic [7:0] got [$];
    logic [7:0] last_out;
    int pulses, fdones;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            pixel_in = 8'hA5;
            v0 = i[0];
            v1 = ~i[0];
            @(posedge clk); #1;
            check("rst_pool_out0", po0, 0);
            check("rst_valid0", vo0, 0);
            check("rst_fdone0", fd0, 0);
            check("rst_valid1", vo1, 0);
            check("rst_fdone1", fd1, 0);
        end
        rst = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        mcol = 0;
        mrow = 0;
        last_out = '0;
        exp_q.delete();
    endtask

    task automatic step(input bit v, input logic [7:0] p);
        logic exp_valid, exp_fd, ov, ofd, other_v;
        logic [7:0] opo, e;
        pixel_in = p;
        v0 = v && (sel == 0);
        v1 = v && (sel == 1);
        exp_valid = 1'b0;
        exp_fd = 1'b0;
        if (v) begin
            frame[mrow][mcol] = p;
            if (mrow % 2 == 1 && mcol % 2 == 1) begin
                exp_q.push_back(max2(max2(frame[mrow-1][mcol-1], frame[mrow-1][mcol]),
                                     max2(frame[mrow][mcol-1], p)));
                exp_valid = 1'b1;
            end
            if (mrow == mh - 1 && mcol == mw - 1) exp_fd = 1'b1;
            if (mcol == mw - 1) begin
                mcol = 0;
                mrow = (mrow == mh - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
        @(posedge clk); #1;
        ov      = (sel == 1) ? vo1 : vo0;
        ofd     = (sel == 1) ? fd1 : fd0;
        opo     = (sel == 1) ? po1 : po0;
        other_v = (sel == 1) ? vo0 : vo1;
        check("valid_out", ov, exp_valid);
        check("frame_done", ofd, exp_fd);
        check("idle_dut_valid", other_v, 0);
        if (ov) begin
            pulses++;
            got.push_back(opo);
            check("scoreboard_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pool_out", opo, e);
                last_out = e;
            end
        end else begin
            check("pool_out_hold", opo, last_out);
        end
        if (ofd) fdones++;
    endtask

    task automatic clear_counts();
        pulses = 0;
        fdones = 0;
        got.delete();
    endtask

    task automatic basic_frame(input bit gapped);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, 8'(r * 4 + c + 1));
                if (gapped) step(1'b0, 8'hEE);
            end
            if (gapped) for (int g = 0; g < 5; g++) step(1'b0, 8'h33);
        end
    endtask

    task automatic window_frame(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d,
                                input logic [7:0] want, input string tag);
        clear_counts();
        for (int i = 0; i < 16; i++) begin
            case (i)
                0: step(1'b1, a);
                1: step(1'b1, b);
                4: step(1'b1, c);
                5: step(1'b1, d);
                default: step(1'b1, 8'd0);
            endcase
        end
        check({tag, "_pulses"}, pulses, 4);
        if (got.size() > 0) check(tag, got[0], want);
    endtask

    task automatic check_basic_vals(input string tag, input int reps);
        logic [7:0] ref_vals [4];
        ref_vals = '{8'd6, 8'd8, 8'd14, 8'd16};
        check({tag, "_pulses"}, pulses, 4 * reps);
        check({tag, "_fdones"}, fdones, reps);
        for (int i = 0; i < got.size() && i < 4 * reps; i++)
            check({tag, "_value"}, got[i], ref_vals[i % 4]);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        sel = 0; mw = 4; mh = 4;
        pixel_in = '0; v0 = 1'b0; v1 = 1'b0;
        clear_counts();

        // 1: reset with toggling valid, then idle
        do_reset(3);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h55);
        check("t1_no_output", pulses, 0);

        // 2: basic contiguous frame
        clear_counts();
        basic_frame(1'b0);
        check_basic_vals("t2", 1);

        // 3: gapped frame
        clear_counts();
        basic_frame(1'b1);
        check_basic_vals("t3", 1);

        // 4: window content
        window_frame(8'd255, 8'd0, 8'd0, 8'd128, 8'd255, "t4_unsigned");
        window_frame(8'd7, 8'd7, 8'd7, 8'd7, 8'd7, "t4_tie");
        window_frame(8'd0, 8'd0, 8'd0, 8'd200, 8'd200, "t4_lower_right");
        window_frame(8'd0, 8'd90, 8'd0, 8'd0, 8'd90, "t4_upper_row");

        // 5: reset mid-frame
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i + 100));
        do_reset(1);
        clear_counts();
        basic_frame(1'b0);
        check_basic_vals("t5", 1);

        // 6a: back-to-back frames
        clear_counts();
        basic_frame(1'b0);
        basic_frame(1'b0);
        check_basic_vals("t6a", 2);

        // 6b: odd dimensions on the 5x3 instance
        sel = 1; mw = 5; mh = 3;
        do_reset(1);
        clear_counts();
        begin
            logic [7:0] odd_img [15];
            odd_img = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd50,
                        8'd5, 8'd6, 8'd7, 8'd8, 8'd60,
                        8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
            for (int i = 0; i < 15; i++) step(1'b1, odd_img[i]);
        end
        step(1'b0, 8'd0);
        check("t6b_pulses", pulses, 2);
        check("t6b_fdones", fdones, 1);
        if (got.size() >= 2) begin
            check("t6b_first", got[0], 6);
            check("t6b_second", got[1], 8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
